// File: rtl/ntt_pkg.sv
// Shared NTT constants: ring/PE geometry, twiddle table depth, table-select codes
// and the twiddle loader state encoding.
package ntt_pkg;

    localparam int RING_DEPTH = 9;
    localparam int PE_DEPTH   = 2;
    localparam int TW_DEPTH   = (1 << (RING_DEPTH - PE_DEPTH)) - 1 + PE_DEPTH;

    localparam logic TW_FWD = 1'b0;
    localparam logic TW_INV = 1'b1;

    typedef enum logic [1:0] {
        TW_IDLE = 2'd0,
        TW_LOAD = 2'd1,
        TW_DONE = 2'd2
    } tw_state_t;

endpackage

// File: rtl/twiddle_ram.sv
// Simple dual-port DEPTH x DLEN twiddle RAM: one write port, one registered read port.
// The array has no reset so it maps onto block or distributed RAM.
module twiddle_ram #(
    parameter int DLEN  = 32,
    parameter int DEPTH = 129,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [DLEN-1:0] wdata,
    input  logic            re,
    input  logic [AW-1:0]   raddr,
    output logic [DLEN-1:0] rdata
);

    logic [DLEN-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/twiddle_bank.sv
// Runtime-loadable forward/inverse twiddle store for PE_COUNT channels: serial
// channel-major loader and a 2-cycle parallel read port shared by all channels.
module twiddle_bank
    import ntt_pkg::*;
#(
    parameter int  DLEN     = 32,
    parameter int  PE_COUNT = 4,
    parameter int  DEPTH    = TW_DEPTH,
    localparam int AW       = $clog2(DEPTH),
    localparam int LCW      = $clog2(PE_COUNT * DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_start,
    input  logic                     load_mode,
    input  logic                     load_valid,
    input  logic [DLEN-1:0]          load_data,
    output logic                     load_ready,
    output logic                     load_done,
    output logic [1:0]               table_ok,
    input  logic                     rd_en,
    input  logic                     rd_mode,
    input  logic [AW-1:0]            rd_addr,
    output logic                     rd_valid,
    output logic [PE_COUNT*DLEN-1:0] rd_data,
    output logic                     rd_err,
    output logic [1:0]               state_dbg
);

    localparam int CW = (PE_COUNT > 1) ? $clog2(PE_COUNT) : 1;
    localparam logic [LCW-1:0] LAST_K = LCW'(PE_COUNT * DEPTH - 1);

    tw_state_t state, state_nxt;

    logic            lmode;
    logic [LCW-1:0]  k;
    logic [CW-1:0]   ch;
    logic [AW-1:0]   waddr;
    logic [1:0]      ok;
    logic            start;
    logic            wr;
    logic            last;

    // Load handshake: a word transfers on every cycle where load_valid and
    // load_ready are both high; the source may hold or drop valid freely.
    assign start = (state == TW_IDLE) && load_start;
    assign wr    = load_valid && load_ready;
    assign last  = wr && (k == LAST_K);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= TW_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        load_ready = 1'b0;
        load_done  = 1'b0;
        case (state)
            TW_IDLE: begin
                if (load_start) state_nxt = TW_LOAD;
            end
            TW_LOAD: begin
                load_ready = 1'b1;
                if (load_valid && (k == LAST_K)) state_nxt = TW_DONE;
            end
            TW_DONE: begin
                load_done = 1'b1;
                state_nxt = TW_IDLE;
            end
            default: state_nxt = TW_IDLE;
        endcase
    end

    // k tracks the flat word index; ch/waddr are its quotient/remainder by DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lmode <= TW_FWD;
            k     <= '0;
            ch    <= '0;
            waddr <= '0;
            ok    <= 2'b00;
        end else begin
            if (start) begin
                lmode         <= load_mode;
                k             <= '0;
                ch            <= '0;
                waddr         <= '0;
                ok[load_mode] <= 1'b0;
            end else if (wr) begin
                k <= k + LCW'(1);
                if (waddr == AW'(DEPTH - 1)) begin
                    waddr <= '0;
                    ch    <= ch + CW'(1);
                end else begin
                    waddr <= waddr + AW'(1);
                end
            end
            if (last) begin
                ok[lmode] <= 1'b1;
            end
        end
    end

    logic                     addr_ok;
    logic                     accept;
    logic                     s1_valid;
    logic                     s1_mode;
    logic [PE_COUNT*DLEN-1:0] q_fwd;
    logic [PE_COUNT*DLEN-1:0] q_inv;

    assign addr_ok = {1'b0, rd_addr} < (AW + 1)'(DEPTH);
    assign accept  = rd_en && ok[rd_mode] && addr_ok;

    for (genvar c = 0; c < PE_COUNT; c++) begin : g_ch
        logic ch_we;
        assign ch_we = wr && (ch == CW'(c));

        twiddle_ram #(.DLEN(DLEN), .DEPTH(DEPTH), .AW(AW)) u_fwd (
            .clk   (clk),
            .we    (ch_we && (lmode == TW_FWD)),
            .waddr (waddr),
            .wdata (load_data),
            .re    (accept),
            .raddr (rd_addr),
            .rdata (q_fwd[c*DLEN +: DLEN])
        );

        twiddle_ram #(.DLEN(DLEN), .DEPTH(DEPTH), .AW(AW)) u_inv (
            .clk   (clk),
            .we    (ch_we && (lmode == TW_INV)),
            .waddr (waddr),
            .wdata (load_data),
            .re    (accept),
            .raddr (rd_addr),
            .rdata (q_inv[c*DLEN +: DLEN])
        );
    end

    // Stage 1 is the RAM read itself; stage 2 selects the table and holds the result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_mode  <= TW_FWD;
            rd_err   <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            s1_valid <= accept;
            s1_mode  <= rd_mode;
            rd_err   <= rd_en && !accept;
            rd_valid <= s1_valid;
            if (s1_valid) begin
                rd_data <= (s1_mode == TW_INV) ? q_inv : q_fwd;
            end
        end
    end

    assign table_ok  = ok;
    assign state_dbg = state;

endmodule

// File: tb/tb_twiddle_bank.sv
// Self-checking bench for twiddle_bank: random loads and reads against a flat
// word-indexed table model with a read scoreboard.
module tb_twiddle_bank;
    import ntt_pkg::*;

    localparam int DLEN     = 32;
    localparam int PE_COUNT = 4;
    localparam int DEPTH    = TW_DEPTH;
    localparam int AW       = $clog2(DEPTH);
    localparam int NW       = PE_COUNT * DEPTH;
    localparam int DW       = PE_COUNT * DLEN;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            load_start = 1'b0;
    logic            load_mode = 1'b0;
    logic            load_valid = 1'b0;
    logic [DLEN-1:0] load_data = '0;
    logic            load_ready;
    logic            load_done;
    logic [1:0]      table_ok;
    logic            rd_en = 1'b0;
    logic            rd_mode = 1'b0;
    logic [AW-1:0]   rd_addr = '0;
    logic            rd_valid;
    logic [DW-1:0]   rd_data;
    logic            rd_err;
    logic [1:0]      state_dbg;

    always #5 clk = ~clk;

    twiddle_bank #(.DLEN(DLEN), .PE_COUNT(PE_COUNT), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .load_mode  (load_mode),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .load_done  (load_done),
        .table_ok   (table_ok),
        .rd_en      (rd_en),
        .rd_mode    (rd_mode),
        .rd_addr    (rd_addr),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_err     (rd_err),
        .state_dbg  (state_dbg)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: each table is a flat list of NW words in load order.
    logic [DLEN-1:0] model_mem [2][NW];
    logic [1:0]      m_ok = 2'b00;
    int              m_phase = 0;
    logic            m_lmode = 1'b0;
    int              m_k = 0;
    bit              acc_d1 = 1'b0;
    logic [DW-1:0]   exp_q[$];
    logic [DW-1:0]   last_data = '0;

    task automatic drive_idle();
        load_start = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        rd_en      = 1'b0;
        rd_mode    = 1'b0;
        rd_addr    = '0;
    endtask

    // One clock with the inputs currently driven; the scoreboard compares afterwards.
    task automatic cycle();
        bit            acc;
        bit            rej;
        bit            exp_vld;
        logic [DW-1:0] word;
        tw_state_t     es;
        acc = rd_en && m_ok[rd_mode] && (int'(rd_addr) < DEPTH);
        rej = rd_en && !acc;
        if (acc) begin
            word = '0;
            for (int c = 0; c < PE_COUNT; c++)
                word[c*DLEN +: DLEN] = model_mem[rd_mode][c*DEPTH + int'(rd_addr)];
            exp_q.push_back(word);
        end
        vectors++;
        if (load_ready !== (m_phase == 1)) begin
            miscompares++;
            $display("FAIL load_ready: got %0b want %0b", load_ready, (m_phase == 1));
        end
        case (m_phase)
            0: if (load_start) begin
                m_phase = 1; m_lmode = load_mode; m_k = 0; m_ok[load_mode] = 1'b0;
            end
            1: if (load_valid) begin
                model_mem[m_lmode][m_k] = load_data;
                m_k++;
                if (m_k == NW) begin m_phase = 2; m_ok[m_lmode] = 1'b1; end
            end
            default: m_phase = 0;
        endcase
        @(posedge clk); #1;
        exp_vld = acc_d1;
        acc_d1  = acc;
        vectors++;
        if (rd_err !== rej) begin
            miscompares++;
            $display("FAIL rd_err: got %0b want %0b", rd_err, rej);
        end
        vectors++;
        if (rd_valid !== exp_vld) begin
            miscompares++;
            $display("FAIL rd_valid: got %0b want %0b", rd_valid, exp_vld);
        end
        if (exp_vld) begin
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL scoreboard_underflow: got empty queue want one entry");
            end else begin
                last_data = exp_q.pop_front();
            end
        end
        vectors++;
        if (rd_data !== last_data) begin
            miscompares++;
            $display("FAIL rd_data: got %h want %h", rd_data, last_data);
        end
        vectors++;
        if (load_done !== (m_phase == 2)) begin
            miscompares++;
            $display("FAIL load_done: got %0b want %0b", load_done, (m_phase == 2));
        end
        vectors++;
        if (table_ok !== m_ok) begin
            miscompares++;
            $display("FAIL table_ok: got %b want %b", table_ok, m_ok);
        end
        es = (m_phase == 1) ? TW_LOAD : (m_phase == 2) ? TW_DONE : TW_IDLE;
        vectors++;
        if (state_dbg !== es) begin
            miscompares++;
            $display("FAIL state: got %0d want %0d", state_dbg, es);
        end
    endtask

    task automatic apply_reset();
        drive_idle();
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_phase = 0; m_k = 0; m_ok = 2'b00;
        acc_d1 = 1'b0; exp_q.delete(); last_data = '0;
    endtask

    task automatic load_table(input logic mode, input int valid_pct, input bit seq_data,
                              input bit stream_reads, input int stop_after,
                              input int restart_at, output int words);
        int guard;
        int rd_ptr;
        guard  = 0;
        rd_ptr = 0;
        words  = 0;
        load_start = 1'b1;
        load_mode  = mode;
        load_valid = 1'b0;
        cycle();
        load_start = 1'b0;
        while (m_phase != 0 && guard < 4000) begin
            if (stop_after > 0 && m_k >= stop_after) break;
            load_valid = ($urandom_range(99) < valid_pct);
            load_data  = seq_data ? DLEN'(m_k + 1) : DLEN'($urandom);
            load_start = (m_k == restart_at);
            load_mode  = ~mode;
            if (stream_reads) begin
                rd_en   = 1'b1;
                rd_mode = ((rd_ptr % 37) == 36) ? mode : ~mode;
                rd_addr = AW'(rd_ptr % DEPTH);
                rd_ptr++;
            end
            if (load_valid && load_ready) words++;
            cycle();
            guard++;
        end
        drive_idle();
        if (guard >= 4000) begin
            vectors++;
            miscompares++;
            $display("FAIL load_timeout: got %0d words want %0d", m_k, NW);
        end
    endtask

    task automatic drain();
        drive_idle();
        cycle();
        cycle();
    endtask

    task automatic read_sweep(input logic mode);
        for (int a = 0; a < DEPTH; a++) begin
            rd_en = 1'b1; rd_mode = mode; rd_addr = AW'(a);
            cycle();
        end
        drain();
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++;
        if ({load_ready, load_done, rd_valid, rd_err} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b want 0000", {load_ready, load_done, rd_valid, rd_err});
        end
        vectors++;
        if (table_ok !== 2'b00 || rd_data !== '0 || state_dbg !== TW_IDLE) begin
            miscompares++;
            $display("FAIL reset_state: got ok=%b st=%0d data=%h want 00/0/0", table_ok, state_dbg, rd_data);
        end
        rd_en = 1'b1; rd_mode = TW_FWD; rd_addr = '0;
        cycle();
        vectors++;
        if (rd_err !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_read_err: got %0b want 1", rd_err);
        end
        drain();
    endtask

    task automatic test_load_w();
        int words;
        load_table(TW_FWD, 100, 1'b1, 1'b0, 0, -1, words);
        vectors++;
        if (words !== NW) begin
            miscompares++;
            $display("FAIL load_w_words: got %0d want %0d", words, NW);
        end
        vectors++;
        if (table_ok !== 2'b01) begin
            miscompares++;
            $display("FAIL load_w_ok: got %b want 01", table_ok);
        end
        rd_en = 1'b1; rd_mode = TW_FWD; rd_addr = AW'(5);
        cycle();
        drive_idle();
        cycle();
        for (int c = 0; c < PE_COUNT; c++) begin
            vectors++;
            if (rd_data[c*DLEN +: DLEN] !== DLEN'(c * DEPTH + 5 + 1)) begin
                miscompares++;
                $display("FAIL addr5_ch%0d: got %0d want %0d", c, rd_data[c*DLEN +: DLEN], c * DEPTH + 6);
            end
        end
        cycle();
    endtask

    task automatic test_load_inv_with_reads();
        int words;
        load_table(TW_INV, 100, 1'b0, 1'b1, 0, -1, words);
        drain();
        vectors++;
        if (table_ok !== 2'b11) begin
            miscompares++;
            $display("FAIL load_inv_ok: got %b want 11", table_ok);
        end
        read_sweep(TW_INV);
    endtask

    task automatic test_random_valid();
        int words;
        load_table(TW_FWD, 50, 1'b0, 1'b0, 0, -1, words);
        vectors++;
        if (words !== NW) begin
            miscompares++;
            $display("FAIL random_valid_words: got %0d want %0d", words, NW);
        end
        read_sweep(TW_FWD);
    endtask

    task automatic test_reset_mid_load();
        int words;
        load_table(TW_INV, 80, 1'b0, 1'b0, 200, -1, words);
        apply_reset();
        vectors++;
        if (table_ok !== 2'b00 || state_dbg !== TW_IDLE) begin
            miscompares++;
            $display("FAIL mid_load_reset: got ok=%b st=%0d want 00/0", table_ok, state_dbg);
        end
        rd_en = 1'b1; rd_mode = TW_INV; rd_addr = AW'(3);
        cycle();
        vectors++;
        if (rd_err !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_load_read_err: got %0b want 1", rd_err);
        end
        drain();
        load_table(TW_INV, 100, 1'b0, 1'b0, 0, -1, words);
        load_table(TW_FWD, 70, 1'b1, 1'b0, 0, -1, words);
        read_sweep(TW_INV);
        read_sweep(TW_FWD);
    endtask

    task automatic test_boundary();
        int words;
        rd_en = 1'b1; rd_mode = TW_FWD; rd_addr = AW'(DEPTH);
        cycle();
        vectors++;
        if (rd_err !== 1'b1) begin
            miscompares++;
            $display("FAIL addr_129_err: got %0b want 1", rd_err);
        end
        rd_mode = TW_INV; rd_addr = '1;
        cycle();
        drain();
        load_table(TW_FWD, 90, 1'b0, 1'b0, 0, 10, words);
        vectors++;
        if (words !== NW) begin
            miscompares++;
            $display("FAIL restart_ignored_words: got %0d want %0d", words, NW);
        end
        vectors++;
        if (table_ok !== 2'b11) begin
            miscompares++;
            $display("FAIL restart_ok: got %b want 11", table_ok);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            rd_en   = ($urandom_range(3) != 0);
            rd_mode = $urandom_range(1);
            rd_addr = ($urandom_range(15) == 0) ? AW'($urandom_range(255)) : AW'($urandom_range(DEPTH + 8));
            cycle();
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_load_w();
        test_load_inv_with_reads();
        test_random_valid();
        test_reset_mid_load();
        test_boundary();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
